// File: rtl/serial_deser.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Define SER_PARITY_EN to add the parity bit, the PAR state and the perr flag.
module serial_deser #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             sin,
   input  logic             sen,
   input  logic             dir,
   output logic [WIDTH-1:0] dout,
   output logic             dvalid,
   output logic             ferr,
   output logic             perr,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
`ifdef SER_PARITY_EN
   localparam logic [1:0] PAR  = 2'd2;
`endif
   localparam logic [1:0] STOP = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             ferr_q, ferr_d;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      ferr_d   = 1'b0;
`ifdef SER_PARITY_EN
      par_d    = par_q;
      perr_d   = 1'b0;
`endif
      if (sen) begin
         case (state_q)
            IDLE: begin
               if (!sin) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  dir_d   = dir;
               end
            end
            DATA: begin
               // dir_q is frozen at the start bit, so a mid-frame dir change is ignored
               sreg_d = dir_q ? {sin, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], sin};
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
                  state_d = PAR;
`else
                  state_d = STOP;
`endif
               end
            end
`ifdef SER_PARITY_EN
            PAR: begin
               par_d   = sin;
               state_d = STOP;
            end
`endif
            STOP: begin
               state_d = IDLE;
               if (!sin) begin
                  ferr_d = 1'b1;
`ifdef SER_PARITY_EN
               end else if (^{sreg_q, par_q}) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  dout_d   = sreg_q;
                  dvalid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef SER_PARITY_EN
         par_q    <= 1'b0;
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ferr_q   <= ferr_d;
`ifdef SER_PARITY_EN
         par_q    <= par_d;
         perr_q   <= perr_d;
`endif
      end
   end

   assign dout   = dout_q;
   assign dvalid = dvalid_q;
   assign ferr   = ferr_q;
   assign busy   = (state_q != IDLE);
`ifdef SER_PARITY_EN
   assign perr   = perr_q;
`else
   assign perr   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8); honours SER_PARITY_EN if defined.
module tb_serial_deser;

   logic       clk;
   logic       clrn;
   logic       sin;
   logic       sen;
   logic       dir;
   logic [7:0] dout;
   logic       dvalid;
   logic       ferr;
   logic       perr;
   logic       busy;

   int checks;
   int errors;

`ifdef SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   serial_deser #(.WIDTH(8)) dut (
      .clk    (clk),
      .clrn   (clrn),
      .sin    (sin),
      .sen    (sen),
      .dir    (dir),
      .dout   (dout),
      .dvalid (dvalid),
      .ferr   (ferr),
      .perr   (perr),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic b, input logic s);
      @(negedge clk);
      sin = b;
      sen = s;
      @(posedge clk);
      #1;
   endtask

   // Full frame with sen held high plus one trailing idle bit; tallies output activity
   task automatic frame(input logic [7:0] bits, input logic pbit, input logic stop,
                        input int flip_at, output int nb, output int nv, output int nf,
                        output int np, output int ppos);
      int idx;
      nb = 0; nv = 0; nf = 0; np = 0; ppos = -1; idx = 0;
      for (int i = 0; i < 11 + PB; i++) begin
         logic b;
         if (i == 0) b = 1'b0;
         else if (i <= 8) begin
            if (i - 1 == flip_at) dir = ~dir;
            b = bits[8-i];
         end else if (PB == 1 && i == 9) b = pbit;
         else if (i == 9 + PB) b = stop;
         else b = 1'b1;
         step(b, 1'b1);
         nb += int'(busy);
         nv += int'(dvalid);
         nf += int'(ferr);
         np += int'(perr);
         if ((dvalid || ferr || perr) && ppos < 0) ppos = idx;
         idx++;
      end
   endtask

   task automatic test_reset();
      clrn = 1'b0; sin = 1'b1; sen = 1'b0; dir = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
      checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", dvalid); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      clrn = 1'b1;
      step(1'b1, 1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_msb_first();
      int nb, nv, nf, np, ppos;
      dir = 1'b0;
      frame(8'b1011_0100, 1'b0, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (dout !== 8'hB4) begin errors++; $display("FAIL msb_dout got %h want b4", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL msb_dvalid_count got %0d want 1", nv); end
      checks++; if (nb !== 9 + PB) begin errors++; $display("FAIL msb_busy_cycles got %0d want %0d", nb, 9 + PB); end
      checks++; if (ppos !== 9 + PB) begin errors++; $display("FAIL msb_latency got %0d want %0d", ppos, 9 + PB); end
      checks++; if (nf + np !== 0) begin errors++; $display("FAIL msb_err_flags got %0d want 0", nf + np); end
   endtask

   task automatic test_lsb_first();
      int nb, nv, nf, np, ppos;
      dir = 1'b1;
      frame(8'b1011_0100, 1'b0, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (dout !== 8'h2D) begin errors++; $display("FAIL lsb_dout got %h want 2d", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL lsb_dvalid_count got %0d want 1", nv); end
      // A dir flip after the start bit must be ignored
      dir = 1'b1;
      frame(8'b1011_0100, 1'b0, 1'b1, 3, nb, nv, nf, np, ppos);
      checks++; if (dout !== 8'h2D) begin errors++; $display("FAIL lsb_dirflip_dout got %h want 2d", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL lsb_dirflip_dvalid got %0d want 1", nv); end
      dir = 1'b0;
   endtask

   task automatic test_frame_error();
      int nb, nv, nf, np, ppos;
      dir = 1'b0;
      frame(8'hFF, 1'b0, 1'b0, -1, nb, nv, nf, np, ppos);
      checks++; if (nf !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", nf); end
      checks++; if (nv !== 0) begin errors++; $display("FAIL ferr_dvalid got %0d want 0", nv); end
      checks++; if (ppos !== 9 + PB) begin errors++; $display("FAIL ferr_pos got %0d want %0d", ppos, 9 + PB); end
      checks++; if (dout !== 8'h2D) begin errors++; $display("FAIL ferr_dout got %h want 2d", dout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got %b want 0", busy); end
      frame(8'h5A, 1'b0, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL ferr_next_dout got %h want 5a", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL ferr_next_dvalid got %0d want 1", nv); end
   endtask

   task automatic test_back_to_back();
      int nv;
      logic [7:0] w0, w1;
      logic [7:0] seen0;
      w0 = 8'hC3; w1 = 8'h81;
      nv = 0; seen0 = 8'h00;
      dir = 1'b0;
      for (int f = 0; f < 2; f++) begin
         logic [7:0] w;
         w = (f == 0) ? w0 : w1;
         step(1'b0, 1'b1);
         nv += int'(dvalid);
         for (int i = 7; i >= 0; i--) begin
            step(w[i], 1'b1);
            nv += int'(dvalid);
         end
         if (PB == 1) begin
            step(^w, 1'b1);
            nv += int'(dvalid);
         end
         step(1'b1, 1'b1);
         nv += int'(dvalid);
         if (f == 0) seen0 = dout;
      end
      step(1'b1, 1'b1);
      nv += int'(dvalid);
      checks++; if (seen0 !== 8'hC3) begin errors++; $display("FAIL b2b_first got %h want c3", seen0); end
      checks++; if (dout !== 8'h81) begin errors++; $display("FAIL b2b_second got %h want 81", dout); end
      checks++; if (nv !== 2) begin errors++; $display("FAIL b2b_dvalid_count got %0d want 2", nv); end
   endtask

   task automatic test_slow_strobe();
      int nb, nv;
      logic [7:0] bits;
      logic b;
      bits = 8'b1011_0100;
      nb = 0; nv = 0;
      dir = 1'b0;
      for (int i = 0; i < 11 + PB; i++) begin
         if (i == 0) b = 1'b0;
         else if (i <= 8) b = bits[8-i];
         else if (PB == 1 && i == 9) b = 1'b0;
         else b = 1'b1;
         for (int k = 0; k < 3; k++) begin
            step(~b, 1'b0);
            nb += int'(busy);
            nv += int'(dvalid);
         end
         step(b, 1'b1);
         nb += int'(busy);
         nv += int'(dvalid);
      end
      checks++; if (dout !== 8'hB4) begin errors++; $display("FAIL slow_dout got %h want b4", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL slow_dvalid_count got %0d want 1", nv); end
      checks++; if (nb !== 36 + 4 * PB) begin errors++; $display("FAIL slow_busy_cycles got %0d want %0d", nb, 36 + 4 * PB); end
   endtask

   task automatic test_mid_frame_reset();
      int nb, nv, nf, np, ppos;
      logic [7:0] bits;
      bits = 8'hF0;
      dir = 1'b0;
      step(1'b0, 1'b1);
      for (int i = 7; i >= 4; i--) step(bits[i], 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      #2 clrn = 1'b0;
      #1;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL midrst_dvalid got %b want 0", dvalid); end
      @(negedge clk);
      clrn = 1'b1;
      sin = 1'b1;
      frame(8'h3C, 1'b0, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL midrst_next_dout got %h want 3c", dout); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL midrst_next_dvalid got %0d want 1", nv); end
   endtask

`ifdef SER_PARITY_EN
   task automatic test_parity();
      int nb, nv, nf, np, ppos;
      dir = 1'b0;
      frame(8'hB4, 1'b0, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (nv !== 1) begin errors++; $display("FAIL par_ok_dvalid got %0d want 1", nv); end
      checks++; if (np !== 0) begin errors++; $display("FAIL par_ok_perr got %0d want 0", np); end
      checks++; if (dout !== 8'hB4) begin errors++; $display("FAIL par_ok_dout got %h want b4", dout); end
      frame(8'h3C, 1'b1, 1'b1, -1, nb, nv, nf, np, ppos);
      checks++; if (np !== 1) begin errors++; $display("FAIL par_bad_perr got %0d want 1", np); end
      checks++; if (nv !== 0) begin errors++; $display("FAIL par_bad_dvalid got %0d want 0", nv); end
      checks++; if (dout !== 8'hB4) begin errors++; $display("FAIL par_bad_dout got %h want b4", dout); end
      checks++; if (ppos !== 10) begin errors++; $display("FAIL par_bad_pos got %0d want 10", ppos); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_frame_error();
      test_back_to_back();
      test_slow_strobe();
      test_mid_frame_reset();
`ifdef SER_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
